// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search block.
// Provides the FSM state encoding, the comparator flag classification and
//   the default width with its matching first (MSB) probe value.
package sar_pkg;

  localparam int SAR_K = 4;
  localparam logic [SAR_K-1:0] MSB_PROBE = SAR_K'(1) << (SAR_K - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    CMP_EQ,
    CMP_GT,
    CMP_LT,
    CMP_BAD
  } cmp_t;

endpackage

// File: rtl/sar_flag_decode.sv
// Classifies the three magnitude-comparator flags into one verdict.
// Combinational, zero latency; no flow control.
// Ports: eq_i/gt_i/lt_i comparator flags in, cls_o verdict out (CMP_BAD unless exactly one flag set).
module sar_flag_decode
  import sar_pkg::*;
(
  input  logic eq_i,
  input  logic gt_i,
  input  logic lt_i,
  output cmp_t cls_o
);

  always_comb begin
    cls_o = CMP_BAD;
    case ({eq_i, gt_i, lt_i})
      3'b100:  cls_o = CMP_EQ;
      3'b010:  cls_o = CMP_GT;
      3'b001:  cls_o = CMP_LT;
      default: cls_o = CMP_BAD;
    endcase
  end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation controller: recovers the comparator's A value MSB-first via probes on B.
// Latency: start at edge 0, first probe in cycle 1, done pulse in cycle 2..K+1.
// No backpressure: start is only sampled in IDLE; starts in SEARCH/DONE are dropped, not queued.
// Ports: clk/rst_n, start request, equal/A_more_B/A_less_B flags in;
//   probe (registered B drive), busy, done pulse, result, steps, error out.
module sar_search
  import sar_pkg::*;
#(
  parameter int K  = SAR_K,
  parameter int CW = $clog2(K + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          equal,
  input  logic          A_more_B,
  input  logic          A_less_B,
  output logic [K-1:0]  probe,
  output logic          busy,
  output logic          done,
  output logic [K-1:0]  result,
  output logic [CW-1:0] steps,
  output logic          error
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;

  state_t          state_q;
  logic [K-1:0]    probe_q;
  logic [K-1:0]    result_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   steps_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;

  cmp_t            cls;
  logic [K-1:0]    bit_i;
  logic [K-1:0]    bit_im1;

  sar_flag_decode u_flag_decode (
    .eq_i  (equal),
    .gt_i  (A_more_B),
    .lt_i  (A_less_B),
    .cls_o (cls)
  );

  // Mask of the bit under test and the next one down; bit_im1 is zero when
  // idx_q==0, which is harmless because that case finishes the search.
  assign bit_i   = K'(1) << idx_q;
  assign bit_im1 = bit_i >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      probe_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      steps_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SEARCH;
            busy_q  <= 1'b1;
            probe_q <= K'(1) << (K - 1);
            idx_q   <= IW'(K - 1);
            steps_q <= '0;
            error_q <= 1'b0;
          end
        end
        SEARCH: begin
          steps_q <= steps_q + CW'(1);
          case (cls)
            CMP_EQ: begin
              result_q <= probe_q;
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
            CMP_GT: begin
              if (idx_q == '0) begin
                result_q <= probe_q;
                state_q  <= DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                probe_q <= probe_q | bit_im1;
                idx_q   <= idx_q - IW'(1);
              end
            end
            CMP_LT: begin
              if (idx_q == '0) begin
                result_q <= probe_q & ~bit_i;
                state_q  <= DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                probe_q <= (probe_q & ~bit_i) | bit_im1;
                idx_q   <= idx_q - IW'(1);
              end
            end
            default: begin
              // Flags not one-hot: comparator fault, abandon the search.
              error_q  <= 1'b1;
              result_q <= '0;
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          endcase
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign probe  = probe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign steps  = steps_q;
  assign error  = error_q;

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;

  localparam int K  = 4;
  localparam int CW = $clog2(K + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [K-1:0]  a_val = '0;
  logic          force_en = 1'b0;
  logic          f_eq = 1'b0, f_gt = 1'b0, f_lt = 1'b0;
  logic          equal, a_more_b, a_less_b;
  logic [K-1:0]  probe, result;
  logic [CW-1:0] steps;
  logic          busy, done, error;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int exp_res;

  // Combinational magnitude comparator on A=a_val, B=probe, with an override
  // so the flags can be forced to illegal patterns.
  assign equal    = force_en ? f_eq : (a_val == probe);
  assign a_more_b = force_en ? f_gt : (a_val >  probe);
  assign a_less_b = force_en ? f_lt : (a_val <  probe);

  sar_search #(.K(K), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .equal    (equal),
    .A_more_B (a_more_b),
    .A_less_B (a_less_b),
    .probe    (probe),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .steps    (steps),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Binary search by arithmetic: try each bit from the top; stop on exact
  // match, otherwise keep the bit when A is above the trial value.
  task automatic model(input int a);
    int known;
    int trial;
    known = 0;
    exp_q.delete();
    exp_res = -1;
    for (int b = K - 1; b >= 0; b--) begin
      trial = known | (1 << b);
      exp_q.push_back(trial);
      if (trial == a) begin
        exp_res = a;
        break;
      end
      if (a > trial) known = trial;
    end
    if (exp_res < 0) exp_res = known;
  endtask

  task automatic run_search(input int a, input bit jitter);
    int n;
    bit got;
    a_val = K'(a);
    model(a);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    got = 1'b0;
    for (int c = 1; c <= K + 2 && !got; c++) begin
      if (c > 1) @(negedge clk);
      if (done) begin
        chk($sformatf("A=%0d done_cycle", a), c, exp_q.size() + 1);
        chk($sformatf("A=%0d result", a), result, exp_res);
        chk($sformatf("A=%0d steps", a), steps, exp_q.size());
        chk($sformatf("A=%0d error", a), error, 0);
        chk($sformatf("A=%0d busy_in_done", a), busy, 0);
        chk($sformatf("A=%0d probe_hold", a), probe, exp_q[exp_q.size() - 1]);
        got = 1'b1;
        start = 1'b0;
      end else begin
        chk($sformatf("A=%0d busy c%0d", a, c), busy, 1);
        chk($sformatf("A=%0d probe%0d", a, n), probe, (n < exp_q.size()) ? exp_q[n] : 32'hFFFF);
        n++;
        if (jitter) start = 1'($urandom_range(0, 1));
      end
    end
    if (!got) chk($sformatf("A=%0d done_timeout", a), 0, 1);
    start = 1'b0;
    @(negedge clk);
    chk($sformatf("A=%0d idle_busy", a), busy, 0);
    chk($sformatf("A=%0d idle_done", a), done, 0);
    chk($sformatf("A=%0d result_hold", a), result, exp_res);
  endtask

  task automatic err_search(input logic e, input logic g, input logic l);
    force_en = 1'b1;
    f_eq = e; f_gt = g; f_lt = l;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("err%0b%0b%0b busy", e, g, l), busy, 1);
    chk($sformatf("err%0b%0b%0b probe", e, g, l), probe, 8);
    @(negedge clk);
    chk($sformatf("err%0b%0b%0b done", e, g, l), done, 1);
    chk($sformatf("err%0b%0b%0b error", e, g, l), error, 1);
    chk($sformatf("err%0b%0b%0b result", e, g, l), result, 0);
    chk($sformatf("err%0b%0b%0b steps", e, g, l), steps, 1);
    force_en = 1'b0;
    f_eq = 1'b0; f_gt = 1'b0; f_lt = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int hold_probe[3];
    int p;
    hold_probe[0] = 8; hold_probe[1] = 4; hold_probe[2] = 6;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst probe", probe, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst steps", steps, 0);
    chk("rst error", error, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", busy, 0);

    // Directed values and boundaries
    run_search(11, 1'b0);
    run_search(8, 1'b0);
    run_search(0, 1'b0);
    run_search(15, 1'b0);

    // Non-one-hot flags
    err_search(1'b0, 1'b0, 1'b0);
    err_search(1'b1, 1'b1, 1'b0);
    err_search(1'b1, 1'b1, 1'b1);

    // Reset during the second SEARCH cycle
    a_val = 4'd5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midrst busy c1", busy, 1);
    @(negedge clk);
    chk("midrst probe c2", probe, 4);
    rst_n = 1'b0;
    #1;
    chk("midrst probe", probe, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst result", result, 0);
    chk("midrst steps", steps, 0);
    chk("midrst error", error, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst no_done", done, 0);
    end
    rst_n = 1'b1;
    run_search(5, 1'b0);

    // start held high: back-to-back searches with one IDLE cycle between
    a_val = 4'd6;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      p = (c - 1) % 5;
      chk($sformatf("hold c%0d busy", c), busy, (p < 3) ? 1 : 0);
      chk($sformatf("hold c%0d done", c), done, (p == 3) ? 1 : 0);
      if (p < 3) chk($sformatf("hold c%0d probe", c), probe, hold_probe[p]);
      if (p == 3) begin
        chk($sformatf("hold c%0d result", c), result, 6);
        chk($sformatf("hold c%0d steps", c), steps, 3);
        chk($sformatf("hold c%0d error", c), error, 0);
      end
    end
    start = 1'b0;
    @(negedge clk);

    // Start pulses while busy must not disturb the search
    run_search(6, 1'b1);
    run_search(6, 1'b1);

    // Random values, some with start jitter while busy
    for (int r = 0; r < 24; r++) begin
      run_search(int'($urandom_range(0, (1 << K) - 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
